// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetchState_e      - fetch FSM state encoding
//   DEFAULT_NOP_INSTR - bubble instruction (sll $0,$0,0)
//   IFID_*            - bit positions of the IF/ID register fields
//   packIfid()        - assembles an IF/ID word from instruction and PC+4
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FULL  = 2'd3
  } fetchState_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  localparam int IFID_W         = 64;
  localparam int IFID_INSTR_MSB = 63;
  localparam int IFID_INSTR_LSB = 32;
  localparam int IFID_PC4_MSB   = 31;
  localparam int IFID_PC4_LSB   = 0;

  function automatic logic [IFID_W-1:0] packIfid(input logic [31:0] instr,
                                                 input logic [31:0] pc4);
    logic [IFID_W-1:0] word;
    word = '0;
    word[IFID_INSTR_MSB:IFID_INSTR_LSB] = instr;
    word[IFID_PC4_MSB:IFID_PC4_LSB]     = pc4;
    return word;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an IF/ID word that arrived
// while decode was stalled.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - capture dataIn and mark the entry full
//   unload     - entry consumed, mark empty
//   clear      - drop the entry (redirect); wins over load/unload
//   dataIn     - word to capture
//   dataOut    - stored word
//   full       - entry holds a valid word
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [IFID_W-1:0] dataIn,
  output logic [IFID_W-1:0] dataOut,
  output logic              full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut <= '0;
      full    <= 1'b0;
    end else if (clear) begin
      full    <= 1'b0;
    end else if (load) begin
      dataOut <= dataIn;
      full    <= 1'b1;
    end else if (unload) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the five-stage MIPS pipeline. Holds the PC, issues
// one instruction-memory request at a time and fills the IF/ID register with
// {instruction, fetch address + 4}, or a NOP bubble when nothing is ready.
//   clk, rst_n          - clock, asynchronous active-low reset
//   BranchControlSignal - taken branch resolved in ID
//   BranchTarget        - redirect address
//   pcHOLD              - load-use stall from ID (beats a branch)
//   imem_req/imem_addr  - request strobe and word address (registered PC)
//   imem_rvalid/rdata   - instruction response
//   IFIDReg             - [63:32] instruction, [31:0] fetch address + 4
//
// state | meaning
// IDLE  | leaving reset, no request yet
// ISSUE | imem_req driven with imem_addr = pc
// WAIT  | request outstanding, waiting for imem_rvalid
// FULL  | word parked in the skid buffer while decode is stalled
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchControlSignal,
  input  logic [31:0]       BranchTarget,
  input  logic              pcHOLD,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [IFID_W-1:0] IFIDReg
);

  fetchState_e       state, stateNext;
  logic [31:0]       pc, pcNext, pcPlus4;
  logic              kill, killNext;
  logic [IFID_W-1:0] ifidNext;
  logic              redirect;
  logic              skidLoad, skidUnload, skidClear, skidFull;
  logic [IFID_W-1:0] skidData;

  assign redirect  = BranchControlSignal & ~pcHOLD;
  assign pcPlus4   = pc + PC_STEP;
  assign imem_req  = (state == ISSUE);
  assign imem_addr = pc;

  fetch_skid_buf uSkid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skidLoad),
    .unload  (skidUnload),
    .clear   (skidClear),
    .dataIn  (packIfid(imem_rdata, pcPlus4)),
    .dataOut (skidData),
    .full    (skidFull)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      IFIDReg <= '0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      kill    <= killNext;
      IFIDReg <= ifidNext;
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    killNext   = kill;
    skidLoad   = 1'b0;
    skidUnload = 1'b0;
    skidClear  = 1'b0;
    // Frozen under stall, otherwise a bubble unless a word is delivered below.
    ifidNext   = pcHOLD ? IFIDReg : packIfid(NOP_INSTR, 32'h0);

    unique case (state)
      IDLE: stateNext = ISSUE;
      ISSUE: begin
        stateNext = WAIT;
        // The request just issued is for the wrong path; drop its response.
        if (redirect) killNext = 1'b1;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect || kill) begin
            killNext  = 1'b0;
            stateNext = ISSUE;
          end else if (pcHOLD) begin
            skidLoad  = 1'b1;
            stateNext = FULL;
          end else begin
            ifidNext  = packIfid(imem_rdata, pcPlus4);
            pcNext    = pcPlus4;
            stateNext = ISSUE;
          end
        end else if (redirect) begin
          killNext = 1'b1;
        end
      end
      FULL: begin
        if (redirect) begin
          skidClear = 1'b1;
          stateNext = ISSUE;
        end else if (!pcHOLD && skidFull) begin
          ifidNext   = skidData;
          skidUnload = 1'b1;
          pcNext     = pcPlus4;
          stateNext  = ISSUE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (redirect) pcNext = BranchTarget;
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        BranchControlSignal = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        pcHOLD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [63:0] IFIDReg;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .BranchControlSignal (BranchControlSignal),
    .BranchTarget        (BranchTarget),
    .pcHOLD              (pcHOLD),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .IFIDReg             (IFIDReg)
  );

  typedef struct {
    logic        hold;
    logic        br;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rd;
    logic        expReq;
    logic [31:0] expAddr;
    logic [63:0] expIfid;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs[NVEC];
  logic [63:0] sbQ[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic hold, input logic br, input logic [31:0] tgt,
                                 input logic rv, input logic [31:0] rd, input logic req,
                                 input logic [31:0] addr, input logic [63:0] ifid);
    vec_t v;
    v.hold = hold; v.br = br; v.tgt = tgt; v.rv = rv; v.rd = rd;
    v.expReq = req; v.expAddr = addr; v.expIfid = ifid;
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'h2400, a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] expAddr;
    logic [31:0] a;
    logic [63:0] e;
    int lat;
    int w;

    //              hold  br    tgt            rv    rd             req   addr           ifid
    vecs[0]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        64'h0);
    vecs[1]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        64'h0);
    vecs[2]  = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,        64'h8C010004_00000004);
    vecs[3]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        64'h0);
    vecs[4]  = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h00221820, 1'b0, 32'h4,        64'h00221820_00000008);
    vecs[5]  = mkVec(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h8,        64'h00221820_00000008);
    vecs[6]  = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hAAAA0008, 1'b0, 32'h8,        64'h00221820_00000008);
    vecs[7]  = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hDEAD0000, 1'b0, 32'h8,        64'h00221820_00000008);
    vecs[8]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        64'hAAAA0008_0000000C);
    vecs[9]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,        64'h0);
    vecs[10] = mkVec(1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 32'hC,        64'h0);
    vecs[11] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40,       64'h0);
    vecs[12] = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'hBADBAD00, 1'b0, 32'h40,       64'h0);
    vecs[13] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40,       64'h0);
    vecs[14] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40,       64'h0);
    vecs[15] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40,       64'h0);
    vecs[16] = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h20420001, 1'b0, 32'h40,       64'h20420001_00000044);
    vecs[17] = mkVec(1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        1'b1, 32'h44,       64'h20420001_00000044);
    vecs[18] = mkVec(1'b1, 1'b1, 32'h80,       1'b1, 32'h11110044, 1'b0, 32'h44,       64'h20420001_00000044);
    vecs[19] = mkVec(1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        1'b0, 32'h44,       64'h0);
    vecs[20] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h80,       64'h0);
    vecs[21] = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h33330080, 1'b0, 32'h80,       64'h33330080_00000084);
    vecs[22] = mkVec(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b1, 32'h84,       64'h0);
    vecs[23] = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h55555555, 1'b0, 32'hFFFFFFFC, 64'h0);
    vecs[24] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 64'h0);
    vecs[25] = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h66666666, 1'b0, 32'hFFFFFFFC, 64'h66666666_00000000);
    vecs[26] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        64'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset req", {63'h0, imem_req}, 64'h0);
    check("reset addr", {32'h0, imem_addr}, 64'h0);
    check("reset ifid", IFIDReg, 64'h0);
    rst_n = 1'b1;

    // Cycle-by-cycle vectors: sequential fetch, hold/skid, branch kill, hold vs branch, wrap
    for (int i = 0; i < NVEC; i++) begin
      pcHOLD = vecs[i].hold;
      BranchControlSignal = vecs[i].br;
      BranchTarget = vecs[i].tgt;
      imem_rvalid = vecs[i].rv;
      imem_rdata = vecs[i].rd;
      #1;
      check($sformatf("vec%0d req", i), {63'h0, imem_req}, {63'h0, vecs[i].expReq});
      check($sformatf("vec%0d addr", i), {32'h0, imem_addr}, {32'h0, vecs[i].expAddr});
      tick();
      check($sformatf("vec%0d ifid", i), IFIDReg, vecs[i].expIfid);
    end
    pcHOLD = 1'b0; BranchControlSignal = 1'b0; BranchTarget = 32'h0;

    // Async reset mid-WAIT with a non-bubble IF/ID, then a stale response in IDLE
    imem_rvalid = 1'b1; imem_rdata = 32'h00000077;
    tick();
    check("pre-reset ifid", IFIDReg, 64'h00000077_00000004);
    imem_rvalid = 1'b0; pcHOLD = 1'b1;
    #1;
    check("pre-reset req", {63'h0, imem_req}, 64'h1);
    check("pre-reset addr", {32'h0, imem_addr}, 64'h4);
    tick();
    pcHOLD = 1'b0;
    check("hold froze ifid", IFIDReg, 64'h00000077_00000004);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset ifid", IFIDReg, 64'h0);
    check("async reset req", {63'h0, imem_req}, 64'h0);
    check("async reset addr", {32'h0, imem_addr}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    check("idle req", {63'h0, imem_req}, 64'h0);
    tick();
    imem_rvalid = 1'b0;
    check("stale rvalid ignored", IFIDReg, 64'h0);
    check("restart req", {63'h0, imem_req}, 64'h1);
    check("restart addr", {32'h0, imem_addr}, 64'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h8C010004;
    tick();
    imem_rvalid = 1'b0;
    check("restart word", IFIDReg, 64'h8C010004_00000004);

    // Scoreboard stream: random memory latency, expectations queued at request time
    expAddr = 32'h4;
    for (int k = 0; k < 16; k++) begin
      w = 0;
      while (!imem_req && w < 8) begin
        tick();
        w++;
      end
      check($sformatf("stream%0d req seen", k), {63'h0, imem_req}, 64'h1);
      a = imem_addr;
      check($sformatf("stream%0d addr", k), {32'h0, a}, {32'h0, expAddr});
      sbQ.push_back({memWord(expAddr), expAddr + 32'd4});
      lat = $urandom_range(1, 4);
      tick();
      repeat (lat - 1) begin
        check($sformatf("stream%0d no early word", k), IFIDReg, 64'h0);
        tick();
      end
      imem_rvalid = 1'b1; imem_rdata = memWord(a);
      tick();
      imem_rvalid = 1'b0;
      if (IFIDReg[31:0] != 32'h0 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check($sformatf("stream%0d ifid", k), IFIDReg, e);
      end else begin
        testsRun++;
        testsFailed++;
        $display("FAIL stream%0d delivery: got %h, expected a fetched word", k, IFIDReg);
        if (sbQ.size() > 0) e = sbQ.pop_front();
      end
      expAddr = expAddr + 32'd4;
    end
    check("scoreboard drained", 64'(sbQ.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
